// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared widths, size/state encodings and alignment check for the LSU
package load_store_unit_pkg;
    localparam int MEMORY_ADDR_W = 32;
    localparam int MEMORY_DATA_W = 32;
    localparam int STRB_W        = 4;
    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_t;
    // size 11 is illegal and always reported as misaligned
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return size == MEM_SIZE_B ? 1'b0 : size == MEM_SIZE_H ? off[0] : size == MEM_SIZE_W ? |off : 1'b1;
    endfunction
endpackage

// File: rtl/load_store_unit_align.sv
// load_align_extend: picks the addressed byte/half of a read word and sign/zero-extends it
//   rdata       in  read word from the bus
//   offset      in  byte offset within the word
//   size        in  access size encoding
//   is_unsigned in  1 = zero-extend, 0 = sign-extend
//   ext         out extended load result
module load_align_extend
    import load_store_unit_pkg::*;
#(
    parameter int DATA_W = MEMORY_DATA_W
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        offset,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] ext
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b   = 8'(rdata >> {offset, 3'b000});
        h   = offset[1] ? rdata[31:16] : rdata[15:0];
        ext = size == MEM_SIZE_B ? {{(DATA_W-8){~is_unsigned & b[7]}}, b} :
              size == MEM_SIZE_H ? {{(DATA_W-16){~is_unsigned & h[15]}}, h} : rdata;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one load/store per instruction over a req/ack data-memory bus
//   req_*        in  memory instruction from execute, sampled only in IDLE
//   stall        out hold PC and pipeline while the access is outstanding
//   done         out one-cycle completion pulse
//   misalign_err out one-cycle pulse when a request is rejected
//   memory_out   out extended load data, held until the next load completes
//   bus_*        req/ack data-memory bus; bus_rdata valid with bus_ack
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = MEMORY_ADDR_W,
    parameter int DATA_W = MEMORY_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              done,
    output logic              misalign_err,
    output logic [DATA_W-1:0] memory_out,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [STRB_W-1:0] bus_wstrb,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);
    lsu_state_t        state, state_n;
    logic [1:0]        size_q, off_q;
    logic              uns_q, mis, accept;
    logic [DATA_W-1:0] wdata_n, ext;
    logic [STRB_W-1:0] wstrb_n;
    always_comb begin
        mis          = misaligned(req_size, req_addr[1:0]);
        accept       = state == IDLE && req_valid && !mis;
        misalign_err = state == IDLE && req_valid && mis;
        stall        = accept || state == BUSY;
        bus_req      = state == BUSY;
        done         = state == DONE;
        state_n      = state == IDLE ? (accept ? BUSY : IDLE) :
                       state == BUSY ? (bus_ack ? DONE : BUSY) : IDLE;
        wdata_n      = req_size == MEM_SIZE_B ? {4{req_wdata[7:0]}} :
                       req_size == MEM_SIZE_H ? {2{req_wdata[15:0]}} : req_wdata;
        wstrb_n      = !req_we ? '0 :
                       req_size == MEM_SIZE_B ? STRB_W'(4'b0001 << req_addr[1:0]) :
                       req_size == MEM_SIZE_H ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    end
    load_align_extend #(.DATA_W(DATA_W)) u_align (
        .rdata(bus_rdata),
        .offset(off_q),
        .size(size_q),
        .is_unsigned(uns_q),
        .ext(ext)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_wstrb  <= '0;
            size_q     <= MEM_SIZE_B;
            off_q      <= 2'b00;
            uns_q      <= 1'b0;
            memory_out <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                bus_we    <= req_we;
                bus_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                bus_wdata <= wdata_n;
                bus_wstrb <= wstrb_n;
                size_q    <= req_size;
                off_q     <= req_addr[1:0];
                uns_q     <= req_unsigned;
            end
            if (state == BUSY && bus_ack && !bus_we)
                memory_out <= ext;
        end
    end
endmodule
